des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
- Iterative DES round-key generator that sits directly upstream of the des round datapath.
- Accepts one 64-bit key plus a direction flag, applies PC-1, then emits the 16 48-bit round subkeys K1..K16 (encrypt) or K16..K1 (decrypt) one per cycle.
- Subkeys go out over a valid/ready stream that the round datapath consumes, one subkey per round.

Parameters:
- CHECK_PARITY, 0: when 1, keys failing DES odd parity in any byte are rejected with key_err instead of being scheduled.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  key offer
- key_ready  out  1  block can accept a key
- key  in  64  DES key; DES bit 1 = key[63]; parity bits (8,16,..,64) ignored by PC-1
- decrypt  in  1  sampled with key: 0 = emit K1..K16, 1 = emit K16..K1
- sk_valid  out  1  subkey on sk is valid
- sk_ready  in  1  consumer accepts subkey
- sk  out  48  current round subkey, PC-2 output; DES bit 1 = sk[47]
- sk_round  out  4  output index 0..15 (0 = first subkey emitted)
- sk_last  out  1  high with the 16th subkey
- key_err  out  1  one-cycle pulse: key rejected for parity (CHECK_PARITY=1 only)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; key_ready=1; sk_valid=0; sk_round=0; sk_last=0; key_err=0.
  - CD register and sk clear to 0.
- States: IDLE, GEN.
- IDLE:
  - key_ready=1; handshake is key_valid&key_ready.
  - On accept with good parity, or with CHECK_PARITY=0:
    - Latch decrypt and load CD <= PC1(key).
    - Rotate before loading: encrypt rotates C and D (28 bits each) left by 1; decrypt does not rotate.
    - Round counter <= 0; go to GEN.
  - On accept with bad parity and CHECK_PARITY=1: key_err=1 next cycle for exactly one cycle; stay in IDLE; CD unchanged.
- GEN:
  - key_ready=0; sk_valid=1; sk=PC2(C,D) from the registered CD (combinational from registers only, stable while stalled).
  - sk_last=(round==15).
  - Stall: sk_valid&~sk_ready holds CD, round, sk and sk_last unchanged.
  - On sk_valid&sk_ready with round<15: round++ and CD rotates for output index n=round+1, where SHIFT[i] = 1 for i in {1,2,9,16} and 2 otherwise:
    - encrypt: left by SHIFT[n+1]
    - decrypt: right by SHIFT[17-n]
  - On sk_valid&sk_ready with round==15: go to IDLE; sk_valid=0 and key_ready=1 on the next cycle; round resets to 0.
- Latency and throughput:
  - Key accepted at edge N gives first subkey valid after edge N; it can be consumed at edge N+1.
  - With sk_ready held high, 16 subkeys arrive in 16 consecutive cycles; the next key can be accepted 17 cycles after the first.
- Decrypt check: total rotation is 28, so decrypt output 0 = PC2(PC1(key)) = K16 and output 15 = K1.
- key_valid in GEN is ignored and not queued; decrypt is only sampled at accept.
- Reset mid-GEN aborts immediately; no partial subkey is valid after reset.
- sk, sk_round and sk_last are don't-care when sk_valid=0, but must not toggle X.

Test Plan:
- Encrypt, stream:
  - Stimulus: key=0x133457799BBCDFF1, decrypt=0, sk_ready=1.
  - Response: sk_valid rises 1 cycle after accept; output 0 sk=0x1B02EFFC7072; output 15 sk=0xCB3D8B0E17F5 with sk_last=1; key_ready returns the cycle after.
- Decrypt:
  - Stimulus: same key, decrypt=1.
  - Response: output 0 = 0xCB3D8B0E17F5, output 15 = 0x1B02EFFC7072; full 16-entry sequence is the exact reverse of the encrypt capture.
- Backpressure:
  - Stimulus: encrypt, sk_ready toggled at random with a 5-cycle stall at round 7.
  - Response: sk and sk_round stable during the stall; the 16 subkeys match the no-stall run in order; no subkey is dropped or duplicated.
- Parity, CHECK_PARITY=1:
  - Stimulus: key=0x133457799BBCDFF0.
  - Response: key_err pulses 1 cycle; sk_valid stays 0; key_ready stays 1. A following key of 0x...F1 schedules normally.
- Async reset:
  - Stimulus: assert rst_n=0 mid-cycle at round 9.
  - Response: sk_valid and sk_last drop to 0 immediately; key_ready=1 after release; a new key restarts at sk_round=0.
- Key offered during GEN:
  - Stimulus: hold key_valid=1 with a second key throughout a schedule.
  - Response: the second key is accepted only after round 15 handshakes; the first schedule is uncorrupted.

Source files
------------

// File: rtl/des_key_schedule.sv
// Iterative DES round-key generator: one key in, sixteen 48-bit subkeys out.
// Latency: first subkey is valid the cycle after key accept; then one subkey per cycle.
// Backpressure: sk_valid&~sk_ready holds all state; key_ready is low for the whole schedule.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   key_valid/key_ready key offer handshake; key is 64 bits, DES bit 1 = key[63]
//   decrypt             sampled with the key: 0 = K1..K16, 1 = K16..K1
//   sk_valid/sk_ready   subkey stream handshake towards the round datapath
//   sk                  PC-2 output, DES bit 1 = sk[47]
//   sk_round            output index 0..15 (0 = first subkey emitted)
//   sk_last             high with the 16th subkey
//   key_err             one-cycle pulse when a key is rejected for bad byte parity
module des_key_schedule #(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [47:0] sk,
  output logic [3:0]  sk_round,
  output logic        sk_last,
  output logic        key_err
);

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  // PC-1: entry i is the DES key bit (1..64) that lands in CD bit i+1.
  // First 28 entries form C, last 28 form D.
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry i is the CD bit (1..56) that lands in subkey bit i+1.
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // DES numbers bits from the MSB, so DES bit b of an N-bit vector is index N-b.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    end
    return r;
  endfunction

  // Round shift table: rounds 1, 2, 9 and 16 rotate by one, all others by two.
  function automatic logic shift_is_one(input logic [4:0] idx);
    return (idx == 5'd1) || (idx == 5'd2) || (idx == 5'd9) || (idx == 5'd16);
  endfunction

  // Left rotation moves DES bit 2 into bit 1, i.e. towards the MSB here.
  function automatic logic [27:0] rotl28(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  function automatic logic odd_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      ok = ok & (^k[b*8 +: 8]);
    end
    return ok;
  endfunction

  state_t      state_q,   state_d;
  logic [55:0] cd_q,      cd_d;
  logic [3:0]  round_q,   round_d;
  logic        dec_q,     dec_d;
  logic        key_err_q, key_err_d;

  logic [55:0] pc1_key;
  logic [55:0] load_cd;
  logic        key_reject;
  logic [4:0]  enc_idx;
  logic [4:0]  dec_idx;
  logic        step_two;
  logic [55:0] step_cd;

  assign pc1_key = pc1(key);

  // Encrypt preloads the first round's rotation so the register already holds
  // C1D1 when the first subkey is presented. Decrypt starts from C0D0, which
  // equals C16D16 because the rotations over a full schedule sum to 28.
  assign load_cd = decrypt ? pc1_key
                           : {rotl28(pc1_key[55:28], 1'b0), rotl28(pc1_key[27:0], 1'b0)};

  assign key_reject = CHECK_PARITY && !odd_parity_ok(key);

  // Moving from output index round_q to round_q+1: encrypt advances into DES
  // round round_q+2, decrypt steps back out of DES round 16-round_q.
  assign enc_idx  = {1'b0, round_q} + 5'd2;
  assign dec_idx  = 5'd16 - {1'b0, round_q};
  assign step_two = dec_q ? !shift_is_one(dec_idx) : !shift_is_one(enc_idx);
  assign step_cd  = dec_q ? {rotr28(cd_q[55:28], step_two), rotr28(cd_q[27:0], step_two)}
                          : {rotl28(cd_q[55:28], step_two), rotl28(cd_q[27:0], step_two)};

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    round_d   = round_q;
    dec_d     = dec_q;
    key_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (key_reject) begin
            key_err_d = 1'b1;
          end else begin
            dec_d   = decrypt;
            cd_d    = load_cd;
            round_d = 4'd0;
            state_d = GEN;
          end
        end
      end
      GEN: begin
        if (sk_ready) begin
          if (round_q == 4'd15) begin
            round_d = 4'd0;
            state_d = IDLE;
          end else begin
            round_d = round_q + 4'd1;
            cd_d    = step_cd;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cd_q      <= '0;
      round_q   <= '0;
      dec_q     <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      round_q   <= round_d;
      dec_q     <= dec_d;
      key_err_q <= key_err_d;
    end
  end

  // All outputs come straight from registers so they hold steady under stall.
  assign key_ready = (state_q == IDLE);
  assign sk_valid  = (state_q == GEN);
  assign sk        = pc2(cd_q);
  assign sk_round  = round_q;
  assign sk_last   = (state_q == GEN) && (round_q == 4'd15);
  assign key_err   = key_err_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: expected subkeys are queued at key
// offer time and popped by an independent monitor on every sk handshake.
// Reference subkeys are the published schedule for key 133457799BBCDFF1.
module tb_des_key_schedule;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key;
  logic        decrypt;
  logic        sk_valid;
  logic        sk_ready;
  logic [47:0] sk;
  logic [3:0]  sk_round;
  logic        sk_last;
  logic        key_err;

  des_key_schedule #(.CHECK_PARITY(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .decrypt   (decrypt),
    .sk_valid  (sk_valid),
    .sk_ready  (sk_ready),
    .sk        (sk),
    .sk_round  (sk_round),
    .sk_last   (sk_last),
    .key_err   (key_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  rnd;
    logic        last;
  } exp_t;

  localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD  = 64'h133457799BBCDFF0;

  logic [47:0] ktab [16];
  exp_t        q [$];
  logic [47:0] cap [16];
  logic [47:0] enc_cap [16];
  int          cap_n;
  int          total;
  int          bad;
  int          bp_mode;
  int          stall_left;
  logic        stall_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_sched(input logic dec);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.sk   = dec ? ktab[15 - i] : ktab[i];
      e.rnd  = 4'(i);
      e.last = (i == 15);
      q.push_back(e);
    end
  endtask

  // Offers a key, waits for it to be taken, then checks the cycle after accept.
  task automatic offer_key(input logic [63:0] k, input logic d, input logic expect_ok);
    int n;
    @(posedge clk); #1;
    cap_n = 0;
    key = k; decrypt = d; key_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 64'(key_ready), 64'd1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    @(negedge clk);
    chk("post_accept_sk_valid", 64'(sk_valid), 64'(expect_ok));
    chk("post_accept_key_err", 64'(key_err), 64'(!expect_ok));
    if (expect_ok) chk("first_sk_round", 64'(sk_round), 64'd0);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((q.size() != 0 || !key_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    chk("drain_key_ready", 64'(key_ready), 64'd1);
  endtask

  // Ready driver: always-ready, or random with one 5-cycle stall at round 7.
  initial begin
    sk_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode == 0) begin
        sk_ready = 1'b1;
      end else if (stall_left > 0) begin
        sk_ready = 1'b0;
        stall_left--;
      end else if (!stall_done && sk_valid && sk_round == 4'd7) begin
        sk_ready   = 1'b0;
        stall_left = 4;
        stall_done = 1'b1;
      end else begin
        sk_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops one expectation per handshake and checks stall stability.
  initial begin
    exp_t        e;
    logic        stall_prev;
    logic [47:0] stall_sk;
    logic [3:0]  stall_rnd;
    stall_prev = 1'b0;
    stall_sk   = '0;
    stall_rnd  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && sk_valid) begin
          total++;
          if (sk !== stall_sk || sk_round !== stall_rnd) begin
            bad++;
            $display("FAIL stall_hold: got sk=%h round=%0d want sk=%h round=%0d",
                     sk, sk_round, stall_sk, stall_rnd);
          end
        end
        if (sk_valid && sk_ready) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_subkey: got sk=%h round=%0d want none", sk, sk_round);
          end else begin
            e = q.pop_front();
            if (sk !== e.sk || sk_round !== e.rnd || sk_last !== e.last) begin
              bad++;
              $display("FAIL subkey: got sk=%h round=%0d last=%0b want sk=%h round=%0d last=%0b",
                       sk, sk_round, sk_last, e.sk, e.rnd, e.last);
            end
          end
          if (cap_n < 16) begin
            cap[cap_n] = sk;
            cap_n++;
          end
        end
        stall_prev = sk_valid && !sk_ready;
        stall_sk   = sk;
        stall_rnd  = sk_round;
      end
    end
  end

  initial begin
    int n;
    ktab = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
             48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
             48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
             48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    total = 0; bad = 0; cap_n = 0;
    bp_mode = 0; stall_left = 0; stall_done = 1'b0;
    rst_n = 1'b0; key_valid = 1'b0; key = '0; decrypt = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_key_ready", 64'(key_ready), 64'd1);
    chk("rst_sk_valid", 64'(sk_valid), 64'd0);
    chk("rst_sk_round", 64'(sk_round), 64'd0);
    chk("rst_sk_last", 64'(sk_last), 64'd0);
    chk("rst_key_err", 64'(key_err), 64'd0);
    chk("rst_sk", 64'(sk), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Encrypt, streaming, with exact timing of last subkey and key_ready return
    push_sched(1'b0);
    offer_key(KEY_GOOD, 1'b0, 1'b1);
    repeat (15) @(negedge clk);
    chk("enc_round15", 64'(sk_round), 64'd15);
    chk("enc_last", 64'(sk_last), 64'd1);
    chk("enc_last_sk", 64'(sk), 64'(ktab[15]));
    @(negedge clk);
    chk("enc_done_key_ready", 64'(key_ready), 64'd1);
    chk("enc_done_sk_valid", 64'(sk_valid), 64'd0);
    drain();
    for (int i = 0; i < 16; i++) enc_cap[i] = cap[i];

    // Decrypt: reversed order
    push_sched(1'b1);
    offer_key(KEY_GOOD, 1'b1, 1'b1);
    drain();
    chk("dec_capture_count", 64'(cap_n), 64'd16);
    for (int i = 0; i < 16; i++) chk("dec_reverse_of_enc", 64'(cap[i]), 64'(enc_cap[15 - i]));

    // Backpressure: random ready plus a 5-cycle stall at round 7
    bp_mode = 1; stall_done = 1'b0; stall_left = 0;
    push_sched(1'b0);
    offer_key(KEY_GOOD, 1'b0, 1'b1);
    drain();
    chk("bp_stall_seen", 64'(stall_done), 64'd1);
    bp_mode = 0;

    // Parity reject, then a good key schedules normally
    offer_key(KEY_BAD, 1'b0, 1'b0);
    @(negedge clk);
    chk("parity_err_one_cycle", 64'(key_err), 64'd0);
    chk("parity_key_ready", 64'(key_ready), 64'd1);
    chk("parity_sk_valid", 64'(sk_valid), 64'd0);
    push_sched(1'b0);
    offer_key(KEY_GOOD, 1'b0, 1'b1);
    drain();

    // Key held during GEN: second offer (decrypt) waits for the first schedule
    push_sched(1'b0);
    @(posedge clk); #1;
    key = KEY_GOOD; decrypt = 1'b0; key_valid = 1'b1;
    @(negedge clk);
    chk("gen_first_ready", 64'(key_ready), 64'd1);
    @(posedge clk); #1;
    decrypt = 1'b1;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("gen_second_wait_ready", 64'(key_ready), 64'd1);
    chk("gen_first_sched_consumed", 64'(q.size()), 64'd0);
    push_sched(1'b1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    @(negedge clk);
    chk("gen_second_valid", 64'(sk_valid), 64'd1);
    chk("gen_second_round0", 64'(sk_round), 64'd0);
    drain();

    // Async reset at round 9
    push_sched(1'b0);
    offer_key(KEY_GOOD, 1'b0, 1'b1);
    n = 0;
    while (sk_round != 4'd9 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_r9", 64'(sk_round), 64'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sk_valid", 64'(sk_valid), 64'd0);
    chk("rst_mid_sk_last", 64'(sk_last), 64'd0);
    chk("rst_mid_sk_round", 64'(sk_round), 64'd0);
    q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_key_ready", 64'(key_ready), 64'd1);
    chk("rst_rel_sk_valid", 64'(sk_valid), 64'd0);
    push_sched(1'b0);
    offer_key(KEY_GOOD, 1'b0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends with a summary line.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
